// File: rtl/if_pipe_reg_if.sv
// if_pipe_reg_if -- fetch-packet bus between the fetch stage and if_pipe_reg.
//
// Handshake: a packet moves upstream->block when i_valid && o_ready at a
// rising edge, and block->downstream when o_valid && i_ready at a rising
// edge. A sender holds its packet stable until it moves. A receiver's
// ready may depend on the sender's valid only within the same cycle.
interface if_pipe_reg_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_W      = 32
);
    logic [FETCH_WIDTH*ADDR_W-1:0] i_pc;
    logic [FETCH_WIDTH-1:0]        i_slot_valid;
    logic                          i_valid;
    logic                          o_ready;
    logic [FETCH_WIDTH*ADDR_W-1:0] o_pc;
    logic [FETCH_WIDTH-1:0]        o_slot_valid;
    logic                          o_valid;
    logic                          i_ready;

    // Pipeline-register side.
    modport slave (
        input  i_pc, i_slot_valid, i_valid, i_ready,
        output o_ready, o_pc, o_slot_valid, o_valid
    );

    // Fetch-stage / downstream side.
    modport master (
        output i_pc, i_slot_valid, i_valid, i_ready,
        input  o_ready, o_pc, o_slot_valid, o_valid
    );
endinterface

// File: rtl/if_pipe_reg.sv
// if_pipe_reg -- IF-stage pipeline register for multi-slot fetch packets.
// Holds one packet on its outputs, drops all-invalid packets (bubbles),
// clears on any flush source and freezes on any stall source. Counts
// cycles the output is blocked in a saturating 16-bit counter.
//
// Optional feature: define IF_PIPE_SKID_EN to add one skid entry behind
// the output register, making o_ready a pure register output. Without it,
// o_ready is computed combinationally from the output state and i_ready.
module if_pipe_reg #(
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_W      = 32,
    parameter int N_FLUSH     = 2,
    parameter int N_STALL     = 2
) (
    input  logic               clk,
    input  logic               rst,
    if_pipe_reg_if.slave       bus,
    input  logic [N_FLUSH-1:0] flush,
    input  logic [N_STALL-1:0] stall,
    output logic [15:0]        o_stall_cnt
);
    localparam int PCW = FETCH_WIDTH * ADDR_W;

    logic any_flush;
    logic any_stall;
    logic drain;
    logic blocked;
    logic accept;
    logic store;

    logic                   out_valid_q, out_valid_d;
    logic [FETCH_WIDTH-1:0] out_sv_q, out_sv_d;
    logic [PCW-1:0]         out_pc_q, out_pc_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

`ifdef IF_PIPE_SKID_EN
    logic                   skid_valid_q, skid_valid_d;
    logic [FETCH_WIDTH-1:0] skid_sv_q, skid_sv_d;
    logic [PCW-1:0]         skid_pc_q, skid_pc_d;
`endif

    assign any_flush = |flush;
    assign any_stall = |stall;
    assign drain     = out_valid_q & bus.i_ready & ~any_stall;
    assign blocked   = out_valid_q & ~drain;

`ifdef IF_PIPE_SKID_EN
    // Skid empty means there is always room for one more packet.
    assign bus.o_ready = ~skid_valid_q;
`else
    assign bus.o_ready = ~out_valid_q | (bus.i_ready & ~any_stall);
`endif

    assign accept = bus.i_valid & bus.o_ready & ~any_flush;
    // Bubbles are consumed by the handshake but never stored.
    assign store  = accept & (|bus.i_slot_valid);

    // Next-state for output register (and skid entry when present).
    always_comb begin
        out_valid_d = out_valid_q;
        out_sv_d    = out_sv_q;
        out_pc_d    = out_pc_q;
`ifdef IF_PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_sv_d    = skid_sv_q;
        skid_pc_d    = skid_pc_q;
`endif
        if (any_flush) begin
            out_valid_d = 1'b0;
            out_sv_d    = '0;
`ifdef IF_PIPE_SKID_EN
            skid_valid_d = 1'b0;
            skid_sv_d    = '0;
`endif
        end else begin
`ifdef IF_PIPE_SKID_EN
            if (drain) begin
                // Skid holds the older packet, so it goes out first.
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_sv_d     = skid_sv_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                    skid_sv_d    = '0;
                end else if (store) begin
                    out_valid_d = 1'b1;
                    out_sv_d    = bus.i_slot_valid;
                    out_pc_d    = bus.i_pc;
                end else begin
                    out_valid_d = 1'b0;
                    out_sv_d    = '0;
                end
            end else if (!out_valid_q) begin
                if (store) begin
                    out_valid_d = 1'b1;
                    out_sv_d    = bus.i_slot_valid;
                    out_pc_d    = bus.i_pc;
                end
            end else if (store) begin
                skid_valid_d = 1'b1;
                skid_sv_d    = bus.i_slot_valid;
                skid_pc_d    = bus.i_pc;
            end
`else
            // o_ready guarantees the output is empty or draining on store.
            if (store) begin
                out_valid_d = 1'b1;
                out_sv_d    = bus.i_slot_valid;
                out_pc_d    = bus.i_pc;
            end else if (drain) begin
                out_valid_d = 1'b0;
                out_sv_d    = '0;
            end
`endif
        end
    end

    // Saturating blocked-cycle counter; flush cycles do not count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!any_flush && blocked && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Control state: valid flags, masks and counter, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sv_q    <= '0;
            stall_cnt_q <= '0;
`ifdef IF_PIPE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_sv_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_sv_q    <= out_sv_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef IF_PIPE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_sv_q    <= skid_sv_d;
`endif
        end
    end

    // PC payload: qualified by the valid flags, so no reset is needed.
    always_ff @(posedge clk) begin
        out_pc_q <= out_pc_d;
`ifdef IF_PIPE_SKID_EN
        skid_pc_q <= skid_pc_d;
`endif
    end

    assign bus.o_valid      = out_valid_q;
    assign bus.o_slot_valid = out_sv_q;
    assign bus.o_pc         = out_pc_q;
    assign o_stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_if_pipe_reg.sv
// tb_if_pipe_reg -- directed testbench for if_pipe_reg (default build or
// IF_PIPE_SKID_EN build).
module tb_if_pipe_reg;
    localparam int FW = 2;
    localparam int AW = 32;

    logic        clk;
    logic        rst;
    logic [1:0]  flush;
    logic [1:0]  stall;
    logic [15:0] o_stall_cnt;

    int n_checks;
    int n_fail;

    if_pipe_reg_if #(.FETCH_WIDTH(FW), .ADDR_W(AW)) bus ();

    if_pipe_reg #(
        .FETCH_WIDTH(FW),
        .ADDR_W     (AW),
        .N_FLUSH    (2),
        .N_STALL    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .flush      (flush),
        .stall      (stall),
        .o_stall_cnt(o_stall_cnt)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pkt(input int k);
        logic [31:0] base;
        base = 32'h1C000000 + 32'(k * 8);
        return {base + 32'd4, base};
    endfunction

    task automatic offer(input logic v, input logic [1:0] mask, input logic [63:0] pc);
        bus.i_valid      = v;
        bus.i_slot_valid = mask;
        bus.i_pc         = pc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush    = 2'b00;
        stall    = 2'b00;
        bus.i_ready = 1'b1;
        offer(1'b1, 2'b11, pkt(9));

        // Reset for two cycles with a packet offered.
        step();
        step();
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_slot_valid", 64'(bus.o_slot_valid), 64'd0);
        check("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
        rst = 1'b0;
        offer(1'b0, 2'b00, 64'd0);
        #1;
        check("rst_o_ready", 64'(bus.o_ready), 64'd1);

        // Streaming: one packet per cycle with downstream always ready.
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 2'b11, pkt(k));
            step();
            check("stream_o_valid", 64'(bus.o_valid), 64'd1);
            check("stream_o_pc", bus.o_pc, pkt(k));
            check("stream_slot_valid", 64'(bus.o_slot_valid), 64'd3);
            check("stream_o_ready", 64'(bus.o_ready), 64'd1);
        end
        check("stream_pc0_exact", pkt(0), {32'h1C000004, 32'h1C000000});
        offer(1'b0, 2'b00, 64'd0);
        step();
        check("stream_empty", 64'(bus.o_valid), 64'd0);
        check("stream_empty_mask", 64'(bus.o_slot_valid), 64'd0);
        check("stream_stall_cnt", 64'(o_stall_cnt), 64'd0);

        // Stall: load A, then stall three cycles while B is offered.
        offer(1'b1, 2'b11, pkt(20));
        step();
        check("stall_load_a", bus.o_pc, pkt(20));
        offer(1'b1, 2'b11, pkt(21));
        stall = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_pc", bus.o_pc, pkt(20));
            check("stall_hold_valid", 64'(bus.o_valid), 64'd1);
            check("stall_o_ready", 64'(bus.o_ready), 64'd0);
        end
        check("stall_cnt3", 64'(o_stall_cnt), 64'd3);
        // Release: A drains and B (held upstream or in skid) follows.
        stall = 2'b00;
        step();
        offer(1'b0, 2'b00, 64'd0);
        check("stall_release_b", bus.o_pc, pkt(21));
        check("stall_release_valid", 64'(bus.o_valid), 64'd1);
        step();
        check("stall_after_empty", 64'(bus.o_valid), 64'd0);
        check("stall_after_cnt", 64'(o_stall_cnt), 64'd3);

        // Flush collision: output full, D blocked/in skid, flush with E offered.
        bus.i_ready = 1'b0;
        offer(1'b1, 2'b11, pkt(30));
        step();
        check("flush_load_c", bus.o_pc, pkt(30));
        offer(1'b1, 2'b11, pkt(31));
        step();
`ifdef IF_PIPE_SKID_EN
        check("flush_skid_full", 64'(bus.o_ready), 64'd0);
`endif
        offer(1'b1, 2'b11, pkt(32));
        flush = 2'b10;
        step();
        check("flush_o_valid", 64'(bus.o_valid), 64'd0);
        check("flush_slot_valid", 64'(bus.o_slot_valid), 64'd0);
        flush = 2'b00;
        offer(1'b0, 2'b00, 64'd0);
        bus.i_ready = 1'b1;
        step();
        check("flush_no_ghost", 64'(bus.o_valid), 64'd0);
        check("flush_o_ready", 64'(bus.o_ready), 64'd1);
        check("flush_cnt", 64'(o_stall_cnt), 64'd4);

        // Bubble, then a single-slot packet.
        offer(1'b1, 2'b00, pkt(40));
        step();
        check("bubble_o_valid", 64'(bus.o_valid), 64'd0);
        offer(1'b1, 2'b01, pkt(41));
        step();
        check("bubble_next_mask", 64'(bus.o_slot_valid), 64'd1);
        check("bubble_next_pc", bus.o_pc, pkt(41));
        offer(1'b0, 2'b00, 64'd0);
        step();
        check("bubble_drained", 64'(bus.o_valid), 64'd0);

        // Saturation: hold G with downstream not ready for 70000 cycles.
        bus.i_ready = 1'b0;
        offer(1'b1, 2'b11, pkt(50));
        step();
        offer(1'b0, 2'b00, 64'd0);
        check("sat_start_cnt", 64'(o_stall_cnt), 64'd4);
        repeat (65530) step();
        check("sat_fffe", 64'(o_stall_cnt), 64'hFFFE);
        step();
        check("sat_ffff", 64'(o_stall_cnt), 64'hFFFF);
        repeat (4469) step();
        check("sat_no_wrap", 64'(o_stall_cnt), 64'hFFFF);
        check("sat_hold_pc", bus.o_pc, pkt(50));
        check("sat_hold_valid", 64'(bus.o_valid), 64'd1);

        // Reset clears a full, saturated block.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst2_cnt", 64'(o_stall_cnt), 64'd0);
        check("rst2_o_ready", 64'(bus.o_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
